// File: rtl/reg_dump.sv
// Sequential register-file reader: walks FIRST_ADDR..LAST_ADDR through one read
// port and streams (address, data) pairs over a valid/ready handshake.
module reg_dump #(
  parameter int FIRST_ADDR = 0,
  parameter int LAST_ADDR  = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  R_addr,
  input  logic [31:0] rdata,
  output logic [4:0]  dump_addr,
  output logic [31:0] dump_data,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] FIRST = 5'(FIRST_ADDR);
  localparam logic [4:0] LAST  = 5'(LAST_ADDR);

  typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

  state_t      state, state_n;
  logic [4:0]  ptr, ptr_n;
  logic [4:0]  dump_addr_n;
  logic [31:0] dump_data_n;
  logic        dump_valid_n, busy_n, done_n;

  // The read port address is the pointer register itself.
  assign R_addr = ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ptr        <= '0;
      dump_addr  <= '0;
      dump_data  <= '0;
      dump_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      dump_addr  <= dump_addr_n;
      dump_data  <= dump_data_n;
      dump_valid <= dump_valid_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

  always_comb begin
    state_n      = state;
    ptr_n        = ptr;
    dump_addr_n  = dump_addr;
    dump_data_n  = dump_data;
    dump_valid_n = dump_valid;
    busy_n       = busy;
    done_n       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = READ;
          ptr_n   = FIRST;
          busy_n  = 1'b1;
        end
      end
      READ: begin
        if (abort) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end else begin
          dump_data_n  = rdata;
          dump_addr_n  = ptr;
          dump_valid_n = 1'b1;
          state_n      = HOLD;
        end
      end
      HOLD: begin
        // Abort wins over a handshake landing on the same edge.
        if (abort) begin
          state_n      = IDLE;
          dump_valid_n = 1'b0;
          busy_n       = 1'b0;
        end else if (dump_valid && dump_ready) begin
          dump_valid_n = 1'b0;
          if (ptr == LAST) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            ptr_n   = ptr + 5'd1;
            state_n = READ;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/reg_dump.md
# reg_dump

Sequential register-file reader for debug and display. On a `start` pulse it walks a contiguous range of register addresses through one read port of the 32×32 register file and streams each (address, data) pair out over a valid/ready handshake. It then signals completion. It sits beside the datapath and drives a spare read-address port; its stream feeds the board display or debug UART logic.

## Interface
- `FIRST_ADDR`, default 0: first register address dumped; legal range 0..31.
- `LAST_ADDR`, default 31: last register address dumped; legal range 0..31, and must be ≥ `FIRST_ADDR`.

Ports:
- `clk`  in  1: single clock; all state changes on posedge.
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin a dump; sampled only in IDLE.
- `abort`  in  1: synchronous cancel of a dump in progress.
- `R_addr`  out  5: read address to the register-file read port.
- `rdata`  in  32: combinational read data returned for `R_addr`.
- `dump_addr`  out  5: address of the current streamed word.
- `dump_data`  out  32: data of the current streamed word.
- `dump_valid`  out  1: stream word valid.
- `dump_ready`  in  1: downstream accepts the word.
- `busy`  out  1: dump in progress.
- `done`  out  1: one-cycle pulse after the last word is accepted.

## Operation
- States: IDLE, READ, HOLD.
- **IDLE:** `start`=1 → READ, `ptr`←`FIRST_ADDR`, `busy`←1. `start` in any other state is ignored.
- **READ:** `R_addr`=`ptr`, where `R_addr` is a register equal to `ptr`. At the next edge:
  - `dump_data`←`rdata`, `dump_addr`←`ptr`, `dump_valid`←1.
  - → HOLD.
- **HOLD:** `dump_valid`, `dump_addr` and `dump_data` hold stable until the handshake (`dump_valid` & `dump_ready`). On the handshake edge:
  - `dump_valid`←0.
  - If `ptr`==`LAST_ADDR`: → IDLE, `busy`←0, `done`←1.
  - Otherwise `ptr`←`ptr`+1, → READ.
- `done` is registered. It is high for exactly one cycle and is cleared at the following edge.
- **abort:** when `abort`=1 in READ or HOLD, at that edge:
  - → IDLE, `dump_valid`←0, `busy`←0.
  - `done` stays 0; `ptr`, `R_addr` and `dump_*` data hold their last values.
  - `abort` has priority over a same-cycle handshake. `abort` in IDLE has no effect.
- Address 0: the register file returns 0, so a dump including address 0 emits data 0x00000000.
- `ptr` never wraps. The sequence ends at `LAST_ADDR`, and `LAST_ADDR`=31 ends without incrementing.
- Consistency: each word reflects the register contents at its own READ-cycle capture edge. A dump is not an atomic snapshot; writes landing on the register file's negedge between captures are visible in later words.
- `start` and `done` in the same cycle: the new dump is accepted, since the state is already IDLE.

## Timing
- **Reset** (`rst`=0, async): state IDLE, `ptr`=0, and all outputs 0: `R_addr`, `dump_addr`, `dump_data`, `dump_valid`, `busy`, `done`. Reset mid-dump discards the dump immediately; there is no `done`.
- **Start latency:** `start` sampled at edge E0 → `busy`=1 and `R_addr`=`FIRST_ADDR` after E0 → `dump_valid`=1 after E1.
- **Throughput:** 2 cycles per word with `dump_ready` held high.
  - Word i (0-based) is accepted at edge E0+2+2i.
  - For N=`LAST_ADDR`−`FIRST_ADDR`+1 words, `done`=1 in the cycle after edge E0+2N, and `busy` falls at that same edge.
- **Backpressure:** each cycle with `dump_ready`=0 in HOLD adds one cycle. The outputs are unchanged during the stall.
- `rdata` must settle within the READ cycle; it is a combinational path from `R_addr`.

## Test plan
- **Reset:** hold `rst`=0 mid-dump → all outputs 0 immediately. Release, then assert `start` → the dump begins at `FIRST_ADDR` with no stale `done`.
- **Full dump, defaults:**
  - Stimulus: preload r[i]=0x1000_0000+i, `dump_ready`=1, `start` at E0.
  - Response: 32 words: (0, 0x00000000), then (i, 0x1000_0000+i) for i=1..31. Word i is accepted at E0+2+2i, `done` pulses after E0+64, and `busy` is high for exactly 64 cycles.
- **Backpressure:** `dump_ready` toggles 0,0,1 repeatedly → each word is held stable for 3 HOLD cycles. Sequence and values are unchanged, with no duplicate or skipped address.
- **Abort:**
  - Stimulus: `abort` together with `dump_ready`=1 during the HOLD of address 7.
  - Response: no handshake, `dump_valid`=0 and `busy`=0 next cycle, and no `done`.
  - Follow-up: a new `start` restarts at `FIRST_ADDR`.
- **Ignored start:** pulse `start` at every cycle of a dump → the sequence is unaffected. A `start` in the `done` cycle launches a second, complete dump.
- **Single word** (`FIRST_ADDR`=`LAST_ADDR`=5, r5=0xDEADBEEF): `start` → one word (5, 0xDEADBEEF) accepted at E0+2, then `done` after E0+2.
